generador_tono: RTL and testbench

Square-wave tone generator that consumes the note code and play-enable produced by the free-play keyboard FSM and drives the speaker/audio pin. It maps note codes 1..4 to programmable half-periods, toggles `audio_out` at that rate while play is requested, and returns to silence when play stops. Note changes take effect only at half-period boundaries, so the output never has a runt pulse.

---
 rtl/tono_pkg.sv | 27 ++
 rtl/tono_divisor.sv | 27 ++
 rtl/generador_tono.sv | 122 ++++++++++++
 tb/tb_generador_tono.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tono_pkg.sv
// Shared constants and types for the tone generator.
package tono_pkg;

    localparam logic [2:0] NOTA_SIL = 3'd0;
    localparam logic [2:0] NOTA_1   = 3'd1;
    localparam logic [2:0] NOTA_2   = 3'd2;
    localparam logic [2:0] NOTA_3   = 3'd3;
    localparam logic [2:0] NOTA_4   = 3'd4;

    // Default half-periods in clk cycles at 50 MHz.
    localparam int unsigned HALF_1_DEF = 95419;
    localparam int unsigned HALF_2_DEF = 85034;
    localparam int unsigned HALF_3_DEF = 75757;
    localparam int unsigned HALF_4_DEF = 71633;
    localparam int          CW_DEF     = 17;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } estado_t;

    // Codes 1..4 are playable notes; 0 and 5..7 mean silence.
    function automatic logic es_nota(input logic [2:0] n);
        return (n >= NOTA_1) && (n <= NOTA_4);
    endfunction

endpackage

// File: rtl/tono_divisor.sv
// Half-period counter: counts while enabled, pulses tc on the last cycle
// of the half-period and wraps itself to zero there.
module tono_divisor #(
    parameter int CW = tono_pkg::CW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [CW:0] half,
    output logic        tc
);

    logic [CW-1:0] cnt;

    assign tc = en && ({1'b0, cnt} == (half - 1'b1));

    // Counter register: clear has priority, terminal count reloads zero.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/generador_tono.sv
// Square-wave tone generator driven by the keyboard FSM note/play signals.
// Optional feature: define GENERADOR_TONO_HOLD_EN to let a stop request
// wait until the end of the current high half-period.
module generador_tono #(
    parameter int unsigned HALF_1 = tono_pkg::HALF_1_DEF,
    parameter int unsigned HALF_2 = tono_pkg::HALF_2_DEF,
    parameter int unsigned HALF_3 = tono_pkg::HALF_3_DEF,
    parameter int unsigned HALF_4 = tono_pkg::HALF_4_DEF,
    parameter int          CW     = tono_pkg::CW_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] nota,
    input  logic       contar,
    output logic       audio_out,
    output logic       tocando,
    output logic [2:0] nota_act
);

    import tono_pkg::*;

    estado_t     estado;
    logic        arranque;
    logic        tc;
    logic        en;
    logic        clr;
    logic [CW:0] half;

    assign arranque = contar && es_nota(nota);
    assign en       = (estado == PLAY);

`ifdef GENERADOR_TONO_HOLD_EN
    logic stop_pend;
    logic fin_pend;

    assign fin_pend = stop_pend || !arranque;
    assign clr      = (estado == IDLE);
`else
    assign clr      = (estado == IDLE) || !arranque;
`endif

    // Half-period lookup for the note currently sounding.
    always_comb begin
        half = (CW+1)'(HALF_1);
        case (nota_act)
            NOTA_2:  half = (CW+1)'(HALF_2);
            NOTA_3:  half = (CW+1)'(HALF_3);
            NOTA_4:  half = (CW+1)'(HALF_4);
            default: half = (CW+1)'(HALF_1);
        endcase
    end

    tono_divisor #(
        .CW (CW)
    ) u_divisor (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .half  (half),
        .tc    (tc)
    );

    // Play FSM with registered outputs; notes change only at half boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= IDLE;
            audio_out <= 1'b0;
            tocando   <= 1'b0;
            nota_act  <= NOTA_SIL;
`ifdef GENERADOR_TONO_HOLD_EN
            stop_pend <= 1'b0;
`endif
        end else begin
            case (estado)
                IDLE: begin
                    if (arranque) begin
                        estado   <= PLAY;
                        tocando  <= 1'b1;
                        nota_act <= nota;
                    end
                end
                PLAY: begin
`ifdef GENERADOR_TONO_HOLD_EN
                    // A pending stop freezes the note and ends on a falling edge.
                    if (tc) begin
                        if (fin_pend && audio_out) begin
                            estado    <= IDLE;
                            audio_out <= 1'b0;
                            tocando   <= 1'b0;
                            nota_act  <= NOTA_SIL;
                            stop_pend <= 1'b0;
                        end else begin
                            audio_out <= ~audio_out;
                            stop_pend <= fin_pend;
                            if (!fin_pend) begin
                                nota_act <= nota;
                            end
                        end
                    end else if (!arranque) begin
                        stop_pend <= 1'b1;
                    end
`else
                    if (!arranque) begin
                        estado    <= IDLE;
                        audio_out <= 1'b0;
                        tocando   <= 1'b0;
                        nota_act  <= NOTA_SIL;
                    end else if (tc) begin
                        audio_out <= ~audio_out;
                        nota_act  <= nota;
                    end
`endif
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generador_tono.sv
// Self-checking bench for generador_tono with HALF_1..4 = 4,5,6,7, CW = 4.
module tb_generador_tono;

    logic       clk = 1'b0;
    logic       reset;
    logic       contar;
    logic [2:0] nota;
    logic       audio_out;
    logic       tocando;
    logic [2:0] nota_act;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: remaining cycles in the current half-period.
    bit m_play = 1'b0;
    bit m_out  = 1'b0;
    bit m_pend = 1'b0;
    int m_note = 0;
    int m_left = 0;

    always #5 clk = ~clk;

    generador_tono #(
        .HALF_1 (4),
        .HALF_2 (5),
        .HALF_3 (6),
        .HALF_4 (7),
        .CW     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .nota      (nota),
        .contar    (contar),
        .audio_out (audio_out),
        .tocando   (tocando),
        .nota_act  (nota_act)
    );

    function automatic int hlf(input int n);
        case (n)
            1:       return 4;
            2:       return 5;
            3:       return 6;
            4:       return 7;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic m_idle();
        m_play = 1'b0;
        m_out  = 1'b0;
        m_pend = 1'b0;
        m_note = 0;
        m_left = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit st;
        st = contar && (nota >= 3'd1) && (nota <= 3'd4);
        if (reset) begin
            m_idle();
        end else if (!m_play) begin
            if (st) begin
                m_play = 1'b1;
                m_note = int'(nota);
                m_left = hlf(m_note);
            end
        end else begin
`ifdef GENERADOR_TONO_HOLD_EN
            m_pend = m_pend || !st;
            m_left--;
            if (m_left == 0) begin
                if (m_pend && m_out) begin
                    m_idle();
                end else begin
                    m_out = !m_out;
                    if (!m_pend) m_note = int'(nota);
                    m_left = hlf(m_note);
                end
            end
`else
            if (!st) begin
                m_idle();
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_out  = !m_out;
                    m_note = int'(nota);
                    m_left = hlf(m_note);
                end
            end
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("model_audio", 32'(audio_out), 32'(m_out));
        chk("model_tocando", 32'(tocando), 32'(m_play));
        chk("model_nota_act", 32'(nota_act), 32'(m_note));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_audio"}, 32'(audio_out), 32'd0);
        chk({tag, "_tocando"}, 32'(tocando), 32'd0);
        chk({tag, "_nota_act"}, 32'(nota_act), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        contar = 1'b1;
        nota   = 3'd2;

        // Reset held with a start present: outputs stay zero.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_zero("reset_hold");
        end
        reset = 1'b0;
        step();
        chk("rel_tocando", 32'(tocando), 32'd1);
        chk("rel_nota_act", 32'(nota_act), 32'd2);
        chk("rel_audio", 32'(audio_out), 32'd0);

        // Note 1 from idle: rises at edges 4 and 12, falls at edge 8.
        reset = 1'b1;
        step();
        reset  = 1'b0;
        contar = 1'b1;
        nota   = 3'd1;
        step();
        chk("n1_tocando", 32'(tocando), 32'd1);
        chk("n1_nota_act", 32'(nota_act), 32'd1);
        chk("n1_audio0", 32'(audio_out), 32'd0);
        for (int e = 1; e <= 12; e++) begin
            step();
            chk("n1_wave", 32'(audio_out), 32'((e / 4) % 2));
        end

        // Note change two cycles after the rise at edge 12.
        step();
        step();
        nota = 3'd4;
        for (int e = 15; e <= 30; e++) begin
            step();
            chk("chg_wave", 32'(audio_out),
                32'((e < 16) ? 1 : (e < 23) ? 0 : (e < 30) ? 1 : 0));
            chk("chg_nota_act", 32'(nota_act), 32'((e < 16) ? 1 : 4));
        end

        // Stop in the middle of a high half of note 3.
        reset = 1'b1;
        step();
        reset = 1'b0;
        nota  = 3'd3;
        step();
        for (int e = 1; e <= 8; e++) step();
        chk("n3_high", 32'(audio_out), 32'd1);
        contar = 1'b0;
        step();
`ifdef GENERADOR_TONO_HOLD_EN
        chk("hold_audio", 32'(audio_out), 32'd1);
        chk("hold_tocando", 32'(tocando), 32'd1);
        chk("hold_nota_act", 32'(nota_act), 32'd3);
        contar = 1'b1;
        step();
        step();
        chk("hold_last_audio", 32'(audio_out), 32'd1);
        step();
        chk_zero("hold_end");
`else
        chk_zero("stop_now");
`endif
        for (int i = 0; i < 4; i++) step();

        // Invalid note code and silence code never start playback.
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        contar = 1'b1;
        nota   = 3'd6;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_zero("nota6");
        end
        nota = 3'd0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_zero("nota0");
        end

        // Reset while the output is high, start held through it.
        nota = 3'd2;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("rp_high", 32'(audio_out), 32'd1);
        reset = 1'b1;
        step();
        chk_zero("rp_reset");
        reset = 1'b0;
        step();
        chk("rp_tocando", 32'(tocando), 32'd1);
        chk("rp_nota_act", 32'(nota_act), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rp_low", 32'(audio_out), 32'd0);
        end
        step();
        chk("rp_rise", 32'(audio_out), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) contar = ~contar;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 3) == 0) nota = 3'($urandom_range(0, 7));
                else nota = 3'($urandom_range(1, 4));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
